matrix_elemwise_alu: RTL



---
 rtl/matrix_elemwise_alu.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/matrix_elemwise_alu.sv
// Element-wise ADD / SUB / reverse SUB / AVERAGE over two packed row-major matrices,
// LANES elements per cycle, with optional saturation, sticky overflow and dimension checking.
module matrix_elemwise_alu #(
    parameter int DATA_W   = 32,
    parameter int MAX_ROWS = 6,
    parameter int MAX_COLS = 6,
    parameter int LANES    = 2,
    parameter int SATURATE = 1,
    localparam int MAX_ELEMS = MAX_ROWS * MAX_COLS,
    localparam int DIM_W     = $clog2(((MAX_ROWS > MAX_COLS) ? MAX_ROWS : MAX_COLS) + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [1:0]                    mode,
    input  logic [DIM_W-1:0]              rows,
    input  logic [DIM_W-1:0]              cols,
    input  logic [MAX_ELEMS*DATA_W-1:0]   Ain,
    input  logic [MAX_ELEMS*DATA_W-1:0]   Bin,
    output logic [MAX_ELEMS*DATA_W-1:0]   Cout,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic                          ovf
);

    localparam int TOT_W = $clog2(MAX_ELEMS + 1);
    localparam int IDX_W = $clog2(MAX_ELEMS + LANES + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2,
        ST_ERR     = 2'd3
    } state_t;

    state_t                        state_r;
    logic [MAX_ELEMS*DATA_W-1:0]   a_r;
    logic [MAX_ELEMS*DATA_W-1:0]   b_r;
    logic [1:0]                    mode_r;
    logic [TOT_W-1:0]              total_r;
    logic [IDX_W-1:0]              idx_r;

    logic [TOT_W-1:0]              prod_s;
    logic                          dim_bad_s;
    logic [IDX_W-1:0]              next_idx_s;
    logic                          last_s;
    logic [IDX_W-1:0]              lane_idx_s [LANES];
    logic [DATA_W-1:0]             lane_res_s [LANES];
    logic [LANES-1:0]              lane_en_s;
    logic [LANES-1:0]              lane_ovf_s;

    // Returns {overflow, result}; operands are widened by one bit so the raw sum never wraps.
    function automatic logic [DATA_W:0] elem_op(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic [1:0]        m);
        logic [DATA_W:0]   a_x;
        logic [DATA_W:0]   b_x;
        logic [DATA_W:0]   sum;
        logic              o;
        logic [DATA_W-1:0] r;
        a_x = {a[DATA_W-1], a};
        b_x = {b[DATA_W-1], b};
        case (m)
            2'b00:   sum = a_x + b_x;
            2'b01:   sum = a_x - b_x;
            2'b10:   sum = b_x - a_x;
            2'b11:   sum = a_x + b_x;
            default: sum = '0;
        endcase
        if (m == 2'b11) begin
            o = 1'b0;
            r = sum[DATA_W:1];
        end else begin
            o = sum[DATA_W] ^ sum[DATA_W-1];
            if (o && (SATURATE != 0)) begin
                r = sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
            end else begin
                r = sum[DATA_W-1:0];
            end
        end
        return {o, r};
    endfunction

    // Dimension check, step bookkeeping and per-lane element results.
    always_comb begin
        prod_s     = TOT_W'(rows) * TOT_W'(cols);
        dim_bad_s  = (rows == DIM_W'(0)) || (cols == DIM_W'(0)) ||
                     (rows > DIM_W'(MAX_ROWS)) || (cols > DIM_W'(MAX_COLS));
        next_idx_s = idx_r + IDX_W'(LANES);
        last_s     = (next_idx_s >= IDX_W'(total_r));
        lane_en_s  = '0;
        lane_ovf_s = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_idx_s[l] = idx_r + IDX_W'(l);
            lane_res_s[l] = '0;
            lane_en_s[l]  = (lane_idx_s[l] < IDX_W'(total_r));
            if (lane_en_s[l]) begin
                {lane_ovf_s[l], lane_res_s[l]} = elem_op(a_r[lane_idx_s[l]*DATA_W +: DATA_W],
                                                         b_r[lane_idx_s[l]*DATA_W +: DATA_W],
                                                         mode_r);
            end else begin
                lane_ovf_s[l] = 1'b0;
            end
        end
    end

    // Control FSM with registered result matrix and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            a_r     <= '0;
            b_r     <= '0;
            mode_r  <= 2'b00;
            total_r <= '0;
            idx_r   <= '0;
            Cout    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && dim_bad_s) begin
                        err     <= 1'b1;
                        done    <= 1'b1;
                        state_r <= ST_ERR;
                    end else if (start) begin
                        a_r     <= Ain;
                        b_r     <= Bin;
                        mode_r  <= mode;
                        total_r <= prod_s;
                        err     <= 1'b0;
                        ovf     <= 1'b0;
                        Cout    <= '0;
                        idx_r   <= '0;
                        busy    <= 1'b1;
                        state_r <= ST_COMPUTE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_COMPUTE: begin
                    for (int l = 0; l < LANES; l++) begin
                        if (lane_en_s[l]) begin
                            Cout[lane_idx_s[l]*DATA_W +: DATA_W] <= lane_res_s[l];
                        end
                    end
                    ovf   <= ovf | (|lane_ovf_s);
                    idx_r <= next_idx_s;
                    if (last_s) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_COMPUTE;
                    end
                end
                ST_DONE: begin
                    if (!start) begin
                        done    <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                ST_ERR: begin
                    if (!start) begin
                        done    <= 1'b0;
                        err     <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_ERR;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
